// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream multiplexer.
// Each cycle one channel is granted, chosen either by the sel port or by a
// round-robin scan that starts at rr_ptr. The granted word is captured into
// a single output register that respects out_ready backpressure. There is no
// combinational path from in_data to out_data.
module stream_mux_arb #(
    parameter int WIDTH = 20,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    logic [WIDTH-1:0] ch_data [N];
    logic [N-1:0]     grant;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             xfer;
    logic [SELW-1:0]  rr_ptr_reg;

    // Unpack the flat input bus into one word per channel.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can accept a word when empty or draining this cycle.
    assign load_en = !out_valid || out_ready;

    // Grant selection: explicit sel (out-of-range grants nothing) or round-robin from rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (int'(sel) == k && in_valid[k]) begin
                    grant[k]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_any && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_any  = 1'b1;
                    grant_idx  = SELW'(idx);
                end
            end
        end
    end

    // Route the granted channel's word towards the output register.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_data = ch_data[k];
            end
        end
    end

    // Ready is suppressed while in reset so no producer sees a phantom handshake.
    assign in_ready = (rst || !load_en) ? '0 : grant;
    assign xfer     = grant_any && load_en;

    // Output register and round-robin pointer; pointer advances only on mode=1 transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            rr_ptr_reg <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (mode) begin
                    rr_ptr_reg <= (int'(grant_idx) == N-1) ? '0 : SELW'(int'(grant_idx) + 1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed testbench for stream_mux_arb: a 4-channel instance for most
// scenarios and a 3-channel instance for out-of-range select behaviour.
module tb_stream_mux_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // 4-channel instance
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [79:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    // 3-channel instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [59:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [19:0] out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int tests_run = 0;
    int tests_failed = 0;

    stream_mux_arb #(.WIDTH(20), .N(4), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    stream_mux_arb #(.WIDTH(20), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [19:0] d0, input logic [19:0] d1,
                            input logic [19:0] d2, input logic [19:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 20'd0 || out_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_initial: got valid=%0b data=%0d ch=%0d expected 0/0/0", out_valid, out_data, out_ch);
        end
        tick;
        tick;
        rst = 1'b0;
        // load a word and hold it with out_ready=0
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
        set_data(20'd99, 20'd0, 20'd0, 20'd0);
        tick;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 20'd99) begin
            tests_failed++;
            $display("FAIL reset_preload: got valid=%0b data=%0d expected 1/99", out_valid, out_data);
        end
        // assert reset mid-cycle; outputs must clear before the next edge
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 20'd0 || out_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got valid=%0b data=%0d ch=%0d expected 0/0/0", out_valid, out_data, out_ch);
        end
        tests_run++;
        if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        $display("[TB] test_reset done");
        tick;
        rst = 1'b0;
        in_valid = 4'b0000;
    endtask

    task automatic test_explicit;
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; out_ready = 1'b1;
        set_data(20'd0, 20'd11, 20'd45, 20'd0);
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL explicit_in_ready: got %b expected 0100", in_ready);
        end
        tick;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 20'd45 || out_ch !== 2'd2) begin
            tests_failed++;
            $display("FAIL explicit_load: got valid=%0b data=%0d ch=%0d expected 1/45/2", out_valid, out_data, out_ch);
        end
        sel = 2'd3;
        #1;
        tests_run++;
        if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL explicit_invalid_sel_ready: got %b expected 0000", in_ready);
        end
        tick;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 20'd45) begin
            tests_failed++;
            $display("FAIL explicit_drain: got valid=%0b data=%0d expected 0/45", out_valid, out_data);
        end
        $display("[TB] test_explicit done");
        in_valid = 4'b0000;
    endtask

    task automatic test_round_robin;
        logic [19:0] exp_d [5];
        logic [1:0]  exp_c [5];
        exp_d[0] = 20'd4;  exp_d[1] = 20'd7;  exp_d[2] = 20'd17; exp_d[3] = 20'd80; exp_d[4] = 20'd4;
        exp_c[0] = 2'd0;   exp_c[1] = 2'd1;   exp_c[2] = 2'd2;   exp_c[3] = 2'd3;   exp_c[4] = 2'd0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(20'd4, 20'd7, 20'd17, 20'd80);
        for (int i = 0; i < 5; i++) begin
            tick;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_ch !== exp_c[i]) begin
                tests_failed++;
                $display("FAIL rr_seq%0d: got valid=%0b data=%0d ch=%0d expected 1/%0d/%0d",
                         i, out_valid, out_data, out_ch, exp_d[i], exp_c[i]);
            end
        end
        in_valid = 4'b0000;
        tick;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_idle: got valid=%0b expected 0", out_valid);
        end
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_backpressure;
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        set_data(20'd0, 20'd24, 20'd0, 20'd0);
        tick;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 20'd24 || out_ch !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_load: got valid=%0b data=%0d ch=%0d expected 1/24/1", out_valid, out_data, out_ch);
        end
        set_data(20'd0, 20'd55, 20'd0, 20'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready%0d: got %b expected 0000", i, in_ready);
            end
            tick;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 20'd24) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid=%0b data=%0d expected 1/24", i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b expected 0010", in_ready);
        end
        tick;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 20'd55 || out_ch !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_next_word: got valid=%0b data=%0d ch=%0d expected 1/55/1", out_valid, out_data, out_ch);
        end
        in_valid = 4'b0000;
        tick;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_rr_skip;
        // rr_ptr is 1 here (left by the round-robin test); a ch2 transfer moves it to 3
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        set_data(20'd4, 20'd7, 20'd17, 20'd80);
        tick;
        tests_run++;
        if (out_data !== 20'd17 || out_ch !== 2'd2) begin
            tests_failed++;
            $display("FAIL skip_setup: got data=%0d ch=%0d expected 17/2", out_data, out_ch);
        end
        in_valid = 4'b0011;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL skip_wrap_grant: got %b expected 0001", in_ready);
        end
        tick;
        tests_run++;
        if (out_data !== 20'd4 || out_ch !== 2'd0) begin
            tests_failed++;
            $display("FAIL skip_ch0: got data=%0d ch=%0d expected 4/0", out_data, out_ch);
        end
        tests_run++;
        if (in_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL skip_next_grant: got %b expected 0010", in_ready);
        end
        tick;
        tests_run++;
        if (out_data !== 20'd7 || out_ch !== 2'd1) begin
            tests_failed++;
            $display("FAIL skip_ch1: got data=%0d ch=%0d expected 7/1", out_data, out_ch);
        end
        in_valid = 4'b0000;
        tick;
        $display("[TB] test_rr_skip done");
    endtask

    task automatic test_sel_range;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b001; out_ready3 = 1'b0;
        in_data3 = {20'd0, 20'd0, 20'd33};
        tick;
        tests_run++;
        if (out_valid3 !== 1'b1 || out_data3 !== 20'd33) begin
            tests_failed++;
            $display("FAIL range_load: got valid=%0b data=%0d expected 1/33", out_valid3, out_data3);
        end
        sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        tests_run++;
        if (in_ready3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL range_ready_held: got %b expected 000", in_ready3);
        end
        tick;
        tests_run++;
        if (out_valid3 !== 1'b1 || out_data3 !== 20'd33) begin
            tests_failed++;
            $display("FAIL range_hold: got valid=%0b data=%0d expected 1/33", out_valid3, out_data3);
        end
        out_ready3 = 1'b1;
        #1;
        tests_run++;
        if (in_ready3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL range_ready_drain: got %b expected 000", in_ready3);
        end
        tick;
        tests_run++;
        if (out_valid3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_drain: got valid=%0b expected 0", out_valid3);
        end
        $display("[TB] test_sel_range done");
    endtask

    initial begin
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; in_data = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = '0; out_ready3 = 1'b0;
        #2;
        test_reset;
        test_explicit;
        test_round_robin;
        test_backpressure;
        test_rr_skip;
        test_sel_range;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
